// File: rtl/raster_pkg.sv
// raster_pkg: fixed-point defaults shared by the edge evaluator, plus the
// function that reduces a wide scaled edge value to the output width.
// Build option: define EDGE_EVAL_SAT_EN to clamp instead of wrap.
package raster_pkg;

    localparam int DEF_INTEGER   = 10;
    localparam int DEF_DECIMAL   = 7;
    localparam int DEF_PRECISION = 1 + DEF_INTEGER + DEF_DECIMAL;
    localparam int DEF_N_EDGES   = 3;

    // Reduce a sign-extended value to prec bits: clamp to the signed range
    // when saturation is built in, otherwise keep the low prec bits.
    function automatic logic signed [63:0] fx_reduce(input logic signed [63:0] v,
                                                     input int unsigned prec);
`ifdef EDGE_EVAL_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (prec - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (64 - prec)) >>> (64 - prec);
`endif
    endfunction

endpackage

// File: rtl/edge_eval_if.sv
// edge_eval_if: polygon load, point input and edge-result handshake bundle.
// master drives polygon/points and accepts results; slave is the evaluator.
interface edge_eval_if
    import raster_pkg::*;
#(
    parameter int PRECISION = DEF_PRECISION,
    parameter int N_EDGES   = DEF_N_EDGES
);
    logic                           tri_load;
    logic [N_EDGES*PRECISION-1:0]   tri_x;
    logic [N_EDGES*PRECISION-1:0]   tri_y;
    logic                           in_vld;
    logic                           in_rdy;
    logic [PRECISION-1:0]           in_px;
    logic [PRECISION-1:0]           in_py;
    logic                           out_vld;
    logic                           out_rdy;
    logic [N_EDGES*PRECISION-1:0]   out_e;
    logic                           out_inside;

    modport master (
        output tri_load, tri_x, tri_y, in_vld, in_px, in_py, out_rdy,
        input  in_rdy, out_vld, out_e, out_inside
    );

    modport slave (
        input  tri_load, tri_x, tri_y, in_vld, in_px, in_py, out_rdy,
        output in_rdy, out_vld, out_e, out_inside
    );
endinterface

// File: rtl/edge_lane.sv
// edge_lane: polygon registers and four-stage datapath for one edge a->b.
// E = dx*(py-ay) - dy*(px-ax); result scaled by 2^-DECIMAL and reduced
// (EDGE_EVAL_SAT_EN selects clamp vs wrap inside fx_reduce).
module edge_lane
    import raster_pkg::*;
#(
    parameter int PRECISION = DEF_PRECISION,
    parameter int DECIMAL   = DEF_DECIMAL
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        load,
    input  logic signed [PRECISION-1:0] ax_in,
    input  logic signed [PRECISION-1:0] ay_in,
    input  logic signed [PRECISION-1:0] bx_in,
    input  logic signed [PRECISION-1:0] by_in,
    input  logic signed [PRECISION-1:0] px,
    input  logic signed [PRECISION-1:0] py,
    output logic signed [PRECISION-1:0] e,
    output logic                        nonneg
);
    localparam int W  = PRECISION + 1;
    localparam int PW = 2 * W;
    localparam int DW = PW + 1;
    localparam int M  = PRECISION - 1;

    logic signed [PRECISION-1:0] ax_r, ay_r;
    logic signed [W-1:0]         dx_r, dy_r;
    logic signed [W-1:0]         s1_ddx, s1_ddy, s1_dx, s1_dy;
    logic signed [PW-1:0]        s2_pa, s2_pb;
    logic signed [DW-1:0]        s3_d;
    logic signed [DW-1:0]        sc;

    // Polygon edge registers; loads ignore the stall so a point accepted on
    // the same edge still sees the previous polygon through S1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ax_r <= '0;
            ay_r <= '0;
            dx_r <= '0;
            dy_r <= '0;
        end else if (load) begin
            ax_r <= ax_in;
            ay_r <= ay_in;
            dx_r <= $signed({bx_in[M], bx_in}) - $signed({ax_in[M], ax_in});
            dy_r <= $signed({by_in[M], by_in}) - $signed({ay_in[M], ay_in});
        end
    end

    assign sc = s3_d >>> DECIMAL;

    // Data stages S1..S4 advance together on en; not reset (qualified by valid).
    always_ff @(posedge clk) begin
        if (en) begin
            s1_ddx <= $signed({px[M], px}) - $signed({ax_r[M], ax_r});
            s1_ddy <= $signed({py[M], py}) - $signed({ay_r[M], ay_r});
            s1_dx  <= dx_r;
            s1_dy  <= dy_r;
            s2_pa  <= PW'(s1_dx) * PW'(s1_ddy);
            s2_pb  <= PW'(s1_dy) * PW'(s1_ddx);
            s3_d   <= DW'(s2_pa) - DW'(s2_pb);
            e      <= PRECISION'(fx_reduce(64'(sc), PRECISION));
            nonneg <= ~s3_d[DW-1];
        end
    end
endmodule

// File: rtl/edge_eval.sv
// edge_eval: convex-polygon edge-function evaluator, N_EDGES parallel lanes,
// 4-cycle latency, 1 point/cycle, global stall on out_rdy.
// Build option: EDGE_EVAL_SAT_EN clamps scaled edge values instead of wrapping.
module edge_eval
    import raster_pkg::*;
#(
    parameter int INTEGER   = DEF_INTEGER,
    parameter int DECIMAL   = DEF_DECIMAL,
    parameter int PRECISION = 1 + INTEGER + DECIMAL,
    parameter int N_EDGES   = DEF_N_EDGES
) (
    input logic         clk,
    input logic         rst_n,
    edge_eval_if.slave  bus
);
    logic [3:0]                   vld;
    logic                         en;
    logic [N_EDGES*PRECISION-1:0] e_all;
    logic [N_EDGES-1:0]           nonneg;

    assign en         = !vld[3] || bus.out_rdy;
    assign bus.in_rdy = en;
    assign bus.out_vld = vld[3];
    assign bus.out_e  = e_all;
    assign bus.out_inside = &nonneg;

    // Stage-valid shift register; bubbles travel with the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld <= '0;
        else if (en) vld <= {vld[2:0], bus.in_vld};
    end

    for (genvar i = 0; i < N_EDGES; i++) begin : g_lane
        localparam int J = (i + 1) % N_EDGES;
        edge_lane #(
            .PRECISION(PRECISION),
            .DECIMAL  (DECIMAL)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .load  (bus.tri_load),
            .ax_in (bus.tri_x[i*PRECISION +: PRECISION]),
            .ay_in (bus.tri_y[i*PRECISION +: PRECISION]),
            .bx_in (bus.tri_x[J*PRECISION +: PRECISION]),
            .by_in (bus.tri_y[J*PRECISION +: PRECISION]),
            .px    (bus.in_px),
            .py    (bus.in_py),
            .e     (e_all[i*PRECISION +: PRECISION]),
            .nonneg(nonneg[i])
        );
    end
endmodule
